// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial audio receiver. Oversamples the codec bit clock in the
// system clock domain and delivers one parallel word per channel slot.
//
// Ports
//   clk            system clock, all state updates on its rising edge
//   resetn         asynchronous active-low reset
//   i2s_bclk       codec bit clock (asynchronous to clk)
//   i2s_lrclk      codec word select, 0 = left slot, 1 = right slot
//   i2s_sdata      codec serial data, MSB first
//   i2s_data_out   last completed word, raw bits as received
//   i2s_data_valid one-clk pulse marking a new word on i2s_data_out
//   i2s_channel    slot of the word on i2s_data_out
//   frame_error    one-clk pulse marking a discarded short slot
//
// Requires f(clk) >= 4 x f(bclk). DATA_WIDTH must be at least 2.

`timescale 1ns/1ps

module i2s_rx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] i2s_data_out,
  output logic                  i2s_data_valid,
  output logic                  i2s_channel,
  output logic                  frame_error
);

  localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Synchronizer and edge-detect pipeline
  logic [1:0] bclk_sync;
  logic [1:0] lr_sync;
  logic [1:0] sd_sync;
  logic       bclk_s;
  logic       lr_s;
  logic       sd_s;
  logic       bclk_d;
  logic       ev_q;
  logic       ev_sd;
  logic       ev_lr;

  // Receiver state
  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-2:0] shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic                  slot_ch;
  logic                  slot_ch_nxt;
  logic                  lr_prev;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt;
  logic                  chan_nxt;
  logic                  ferr_nxt;

  logic                  boundary;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] word_c;

  assign bclk_s = bclk_sync[1];
  assign lr_s   = lr_sync[1];
  assign sd_s   = sd_sync[1];

  // Two-flop synchronizers, registered rising-edge detect of bclk_s.
  // The sampled data and word select travel with the event so that
  // later bclk transitions cannot skew what the FSM sees.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bclk_sync <= 2'b00;
      lr_sync   <= 2'b00;
      sd_sync   <= 2'b00;
      bclk_d    <= 1'b0;
      ev_q      <= 1'b0;
      ev_sd     <= 1'b0;
      ev_lr     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i2s_bclk};
      lr_sync   <= {lr_sync[0], i2s_lrclk};
      sd_sync   <= {sd_sync[0], i2s_sdata};
      bclk_d    <= bclk_s;
      ev_q      <= bclk_s & ~bclk_d;
      ev_sd     <= sd_s;
      ev_lr     <= lr_s;
    end
  end

  // A word-select change seen at a bit event marks a slot boundary; the bit
  // sampled there still belongs to the previous slot (one-bit I2S delay).
  assign boundary = ev_q && (ev_lr != lr_prev);
  assign last_bit = (bit_cnt == LAST_CNT);
  assign word_c   = {shreg, ev_sd};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (ev_q) begin
      case (state)
        ST_IDLE: begin
          if (boundary) state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (boundary)      state_nxt = ST_SHIFT;
          else if (last_bit) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (boundary) state_nxt = ST_SHIFT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    slot_ch_nxt = slot_ch;
    data_nxt    = i2s_data_out;
    chan_nxt    = i2s_channel;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    if (boundary) begin
      // Close the slot that just ended, then start a new one
      if (state == ST_SHIFT) begin
        if (last_bit) begin
          data_nxt  = word_c;
          chan_nxt  = slot_ch;
          valid_nxt = 1'b1;
        end else begin
          ferr_nxt  = 1'b1;
        end
      end
      bit_cnt_nxt = '0;
      slot_ch_nxt = ev_lr;
    end else if (ev_q && (state == ST_SHIFT)) begin
      shreg_nxt   = word_c[DATA_WIDTH-2:0];
      bit_cnt_nxt = bit_cnt + CNT_W'(1);
      // Word complete inside a wide slot; remaining bits are padding
      if (last_bit) begin
        data_nxt  = word_c;
        chan_nxt  = slot_ch;
        valid_nxt = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      slot_ch        <= 1'b0;
      lr_prev        <= 1'b0;
      i2s_data_out   <= '0;
      i2s_data_valid <= 1'b0;
      i2s_channel    <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      shreg          <= shreg_nxt;
      bit_cnt        <= bit_cnt_nxt;
      slot_ch        <= slot_ch_nxt;
      if (ev_q) lr_prev <= ev_lr;
      i2s_data_out   <= data_nxt;
      i2s_data_valid <= valid_nxt;
      i2s_channel    <= chan_nxt;
      frame_error    <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: clk 100 MHz, bclk = clk/8, DATA_WIDTH = 16.
`timescale 1ns/1ps

module tb_i2s_rx;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          resetn;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic [DW-1:0] i2s_data_out;
  logic          i2s_data_valid;
  logic          i2s_channel;
  logic          frame_error;

  int          n_vec = 0;
  int          n_err = 0;
  int          ferr_cnt = 0;
  bit          both_seen = 1'b0;
  logic [16:0] vq[$];
  logic        carry;
  int          lat;

  i2s_rx #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .i2s_data_out   (i2s_data_out),
    .i2s_data_valid (i2s_data_valid),
    .i2s_channel    (i2s_channel),
    .frame_error    (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output pulse, sampled on the falling clk edge
  always @(negedge clk) begin
    if (i2s_data_valid) vq.push_back({i2s_channel, i2s_data_out});
    if (frame_error) ferr_cnt++;
    if (i2s_data_valid && frame_error) both_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < vq.size()) return {15'b0, vq[i]};
    return 'x;
  endfunction

  // One bit period: data and word select change with bclk low, sampled on the rise
  task automatic send_bit(input logic lr, input logic sd);
    i2s_lrclk = lr;
    i2s_sdata = sd;
    #40;
    i2s_bclk = 1'b1;
    #40;
    i2s_bclk = 1'b0;
  endtask

  // One slot of n bit periods: the first carries the previous slot's last bit
  task automatic send_slot(input logic lr, input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) send_bit(lr, carry);
      else        send_bit(lr, pat[n - i]);
    end
    carry = pat[0];
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    carry     = 1'b0;
    lat       = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data",  32'(i2s_data_out),   32'h0);
    chk("rst_valid", 32'(i2s_data_valid), 32'h0);
    chk("rst_chan",  32'(i2s_channel),    32'h0);
    chk("rst_ferr",  32'(frame_error),    32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // bclk and data running with no word-select transition yet
    send_slot(1'b0, 32'h0000_0A5C, 12);
    settle();
    chk("preroll_words", vq.size(), 32'd0);
    chk("preroll_ferr",  ferr_cnt,  32'd0);

    // 16-bit slots
    send_slot(1'b1, 32'h0000_0F0F, 16);
    send_slot(1'b0, 32'h0000_1234, 16);
    send_slot(1'b1, 32'h0000_ABCD, 16);
    settle();
    chk("std_words", vq.size(), 32'd2);

    // 32-bit slots with ones padding
    send_slot(1'b0, 32'h8001_FFFF, 32);
    send_slot(1'b1, 32'h7FFE_FFFF, 32);
    settle();
    chk("wide_words", vq.size(), 32'd5);
    chk("wide_ferr",  ferr_cnt,  32'd0);

    // Short 9-bit slot, then a full slot
    send_slot(1'b0, 32'h0000_01A5, 9);
    send_slot(1'b1, 32'h0000_C3A5, 16);
    settle();
    chk("short_ferr",  ferr_cnt,  32'd1);
    chk("short_words", vq.size(), 32'd5);

    // Reset in the middle of a left word
    send_slot(1'b0, 32'h0000_5A3C, 16);
    send_slot(1'b1, 32'h0000_6789, 16);
    send_slot(1'b0, 32'h0000_00DE, 8);
    settle();
    chk("prerst_words", vq.size(), 32'd8);
    chk("prerst_data",  32'(i2s_data_out), 32'h6789);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_data",  32'(i2s_data_out),   32'h0);
    chk("midrst_valid", 32'(i2s_data_valid), 32'h0);
    chk("midrst_chan",  32'(i2s_channel),    32'h0);
    chk("midrst_ferr",  32'(frame_error),    32'h0);
    #30;
    resetn = 1'b1;
    @(negedge clk);
    send_slot(1'b0, 32'h0000_00AD, 8);
    settle();
    chk("postrst_words", vq.size(), 32'd8);
    send_slot(1'b1, 32'h0000_BEEF, 16);
    send_slot(1'b0, 32'h0000_2468, 16);
    send_slot(1'b1, 32'h0000_1357, 16);

    // Latency from the raw bclk rise carrying the LSB to the valid pulse
    @(negedge clk);
    i2s_lrclk = 1'b0;
    i2s_sdata = carry;
    #40;
    i2s_bclk = 1'b1;
    lat = 0;
    while (!i2s_data_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_clk", lat, 32'd4);
    @(negedge clk);
    #40;
    i2s_bclk = 1'b0;
    settle();

    chk("total_words", vq.size(), 32'd11);
    chk("total_ferr",  ferr_cnt,  32'd1);
    chk("valid_ferr_overlap", 32'(both_seen), 32'd0);
    chk("word0",  q_at(0),  {15'b0, 1'b1, 16'h0F0F});
    chk("word1",  q_at(1),  {15'b0, 1'b0, 16'h1234});
    chk("word2",  q_at(2),  {15'b0, 1'b1, 16'hABCD});
    chk("word3",  q_at(3),  {15'b0, 1'b0, 16'h8001});
    chk("word4",  q_at(4),  {15'b0, 1'b1, 16'h7FFE});
    chk("word5",  q_at(5),  {15'b0, 1'b1, 16'hC3A5});
    chk("word6",  q_at(6),  {15'b0, 1'b0, 16'h5A3C});
    chk("word7",  q_at(7),  {15'b0, 1'b1, 16'h6789});
    chk("word8",  q_at(8),  {15'b0, 1'b1, 16'hBEEF});
    chk("word9",  q_at(9),  {15'b0, 1'b0, 16'h2468});
    chk("word10", q_at(10), {15'b0, 1'b1, 16'h1357});

    // Outputs hold after the pulse
    repeat (8) @(negedge clk);
    #1;
    chk("hold_data",  32'(i2s_data_out),   32'h1357);
    chk("hold_chan",  32'(i2s_channel),    32'h1);
    chk("hold_valid", 32'(i2s_data_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
